// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_asm.sv
// rtl/imem_loader_asm.sv - little-endian byte-to-word assembler for the imem loader
module imem_loader_asm
    import imem_loader_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    localparam int BPW    = (INSTR_W + 7) / 8;
    localparam int FULL_W = BPW * BYTE_W;

    generate
        if (BPW == 1) begin : g_one
            // A single byte already is a whole word; nothing to hold.
            assign word_valid = byte_valid;
            assign word       = byte_data[INSTR_W-1:0];
        end else begin : g_multi
            localparam int SR_W = (BPW - 1) * BYTE_W;

            logic [SR_W-1:0]   sr;
            logic [SR_W-1:0]   sr_next;
            logic [1:0]        idx;
            logic [FULL_W-1:0] full;

            // The current byte completes the word, so the word is formed
            // combinationally and the top can register it on the same edge.
            assign full       = {byte_data, sr};
            assign word_valid = byte_valid && (idx == 2'(BPW - 1));
            assign word       = full[INSTR_W-1:0];

            if (BPW == 2) begin : g_shift2
                assign sr_next = byte_data;
            end else begin : g_shiftn
                assign sr_next = {byte_data, sr[SR_W-1:BYTE_W]};
            end

            // Shift bytes in from the top so the first byte ends lowest.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr  <= '0;
                    idx <= '0;
                end else if (clear) begin
                    idx <= '0;
                end else if (byte_valid) begin
                    sr  <= sr_next;
                    idx <= word_valid ? 2'd0 : idx + 2'd1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream loader for imem (option: IMEM_LOADER_CHECKSUM_EN)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    state_t             state;
    state_t             state_next;
    logic [7:0]         n_lo;
    logic [15:0]        n_words;
    logic [ADDR_W:0]    word_cnt;
    logic               accept;
    logic [15:0]        n_full;
    logic               last_word;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    assign accept    = s_valid && s_ready;
    assign n_full    = {s_data, n_lo};
    // word_cnt is one bit wider than the address so a full image of
    // 2^ADDR_W words compares correctly without wrapping.
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(n_words);

    imem_loader_asm #(
        .INSTR_W (INSTR_W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == LEN_HI),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start is only honoured when not mid-load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = LEN_LO;
            LEN_LO: if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end else if (32'(n_full) > CAP) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:    if (accept) state_next = (s_data == chk) ? DONE : ERR;
`endif
            DONE:   if (start) state_next = LEN_LO;
            ERR:    if (start) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and datapath; status flags follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            n_lo     <= '0;
            n_words  <= '0;
            word_cnt <= '0;
        end else begin
            s_ready  <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                        (state_next == DATA)   || (state_next == CHK);
            done     <= (state_next == DONE);
            err      <= (state_next == ERR);
            cpu_hold <= (state_next != DONE);
            wr_en    <= 1'b0;
            if (accept && (state == LEN_LO)) begin
                n_lo <= s_data;
            end
            if (accept && (state == LEN_HI)) begin
                n_words  <= n_full;
                word_cnt <= '0;
            end
            if (word_valid) begin
                wr_en    <= 1'b1;
                wr_data  <= word;
                wr_addr  <= word_cnt[ADDR_W-1:0];
                word_cnt <= word_cnt + 1'b1;
            end
            if (start && ((state == DONE) || (state == ERR))) begin
                word_cnt <= '0;
                wr_addr  <= '0;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of every byte from N_lo onward; restarts on N_lo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk <= '0;
        end else if (accept) begin
            chk <= (state == LEN_LO) ? s_data : (chk ^ s_data);
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    imem_loader #(.INSTR_W(16), .ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        done_at;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) begin
        if (wr_en && !rst) wq.push_back('{wr_addr, wr_data, done});
    end

    typedef struct packed {
        logic [7:0]  len;
        logic [95:0] bytes;
        logic        exp_done;
        logic        exp_err;
        logic [2:0]  nwr;
        logic [63:0] wd;
    } vec_t;

    vec_t vecs [8];
    int   nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int bound;
        @(negedge clk);
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_data  = b;
        s_valid = 1'b1;
        bound   = 0;
        while (!s_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed 0 for byte %0h", b);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic exp_d;
        wq.delete();
        pulse_start();
        for (int i = 0; i < int'(v.len); i++) begin
            send(v.bytes[(int'(v.len) - 1 - i) * 8 +: 8], 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check($sformatf("v%0d_done", idx), done, v.exp_done);
        check($sformatf("v%0d_err", idx), err, v.exp_err);
        check($sformatf("v%0d_hold", idx), cpu_hold, !v.exp_done);
        check($sformatf("v%0d_ready", idx), s_ready, 0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_nwr", idx), wq.size(), v.nwr);
        for (int j = 0; j < int'(v.nwr) && j < wq.size(); j++) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_d = 1'b0;
`else
            exp_d = (j == int'(v.nwr) - 1) && v.exp_done;
`endif
            check($sformatf("v%0d_addr%0d", idx, j), wq[j].addr, j);
            check($sformatf("v%0d_data%0d", idx, j), wq[j].data,
                  v.wd[(int'(v.nwr) - 1 - j) * 16 +: 16]);
            check($sformatf("v%0d_done_at%0d", idx, j), wq[j].done_at, exp_d);
        end
    endtask

    logic [15:0] gap_words [4];
    logic [7:0]  x;
    logic [7:0]  lo;

    initial begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[0] = '{8'd7, 96'h02003412CDAB42, 1'b1, 1'b0, 3'd2, 64'h1234ABCD};
        vecs[1] = '{8'd3, 96'h000000,         1'b1, 1'b0, 3'd0, 64'h0};
        vecs[2] = '{8'd2, 96'h0101,           1'b0, 1'b1, 3'd0, 64'h0};
        vecs[3] = '{8'd5, 96'h0100EFBE50,     1'b1, 1'b0, 3'd1, 64'hBEEF};
        vecs[4] = '{8'd5, 96'h0100341227,     1'b1, 1'b0, 3'd1, 64'h1234};
        vecs[5] = '{8'd5, 96'h0100341200,     1'b0, 1'b1, 3'd1, 64'h1234};
        nvec = 6;
`else
        vecs[0] = '{8'd6, 96'h02003412CDAB,   1'b1, 1'b0, 3'd2, 64'h1234ABCD};
        vecs[1] = '{8'd2, 96'h0000,           1'b1, 1'b0, 3'd0, 64'h0};
        vecs[2] = '{8'd2, 96'h0101,           1'b0, 1'b1, 3'd0, 64'h0};
        vecs[3] = '{8'd4, 96'h0100EFBE,       1'b1, 1'b0, 3'd1, 64'hBEEF};
        nvec = 4;
`endif

        // Reset values.
        #12;
        check("rst_ready", s_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", s_ready, 0);

        for (int k = 0; k < nvec; k++) apply_vec(vecs[k], k);

        // N=4 with random valid gaps and a stray start mid-load.
        gap_words[0] = 16'hA1B2;
        gap_words[1] = 16'hC3D4;
        gap_words[2] = 16'hE5F6;
        gap_words[3] = 16'h0718;
        wq.delete();
        pulse_start();
        send(8'h04, $urandom_range(0, 1));
        send(8'h00, $urandom_range(0, 1));
        x = 8'h04;
        for (int w = 0; w < 4; w++) begin
            send(gap_words[w][7:0], $urandom_range(0, 1));
            send(gap_words[w][15:8], $urandom_range(0, 1));
            x = x ^ gap_words[w][7:0] ^ gap_words[w][15:8];
            if (w == 1) begin
                @(negedge clk);
                s_valid = 1'b0;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(x, 1);
`endif
        @(negedge clk);
        s_valid = 1'b0;
        check("gap_done", done, 1);
        repeat (3) @(negedge clk);
        check("gap_nwr", wq.size(), 4);
        for (int j = 0; j < 4 && j < wq.size(); j++) begin
            check($sformatf("gap_addr%0d", j), wq[j].addr, j);
            check($sformatf("gap_data%0d", j), wq[j].data, gap_words[j]);
        end

        // Full capacity: N = 256, last write at address 255.
        wq.delete();
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        x = 8'h01;
        for (int i = 0; i < 256; i++) begin
            lo = 8'(i);
            send(lo, 0);
            send(~lo, 0);
            x = x ^ lo ^ ~lo;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(x, 0);
`endif
        @(negedge clk);
        s_valid = 1'b0;
        check("cap_done", done, 1);
        check("cap_err", err, 0);
        repeat (3) @(negedge clk);
        check("cap_nwr", wq.size(), 256);
        for (int j = 0; j < 256 && j < wq.size(); j++) begin
            lo = 8'(j);
            check($sformatf("cap_addr%0d", j), wq[j].addr, j);
            check($sformatf("cap_data%0d", j), wq[j].data, {~lo, lo});
        end

        // Asynchronous reset after three data bytes.
        wq.delete();
        pulse_start();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        send(8'h12, 0);
        send(8'hCD, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ready", s_ready, 0);
        check("arst_wr_en", wr_en, 0);
        check("arst_addr", wr_addr, 0);
        check("arst_data", wr_data, 0);
        check("arst_hold", cpu_hold, 1);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        s_data  = 8'hAB;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("arst_idle_ready", s_ready, 0);
        check("arst_no_wr", wq.size(), 0);
        apply_vec(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that fills the controller's instruction memory at run time, in place of a preload.
- Sits directly upstream of the CPU top.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles bytes into instruction words.
- Issues one imem write per word and holds the CPU in reset until the image is fully loaded.

Parameters:
- INSTR_W, 16, instruction word width in bits (1..32).
- ADDR_W, 8, imem address width; capacity 2^ADDR_W words.
- BPW, (INSTR_W+7)/8, bytes per word; derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  imem write strobe, one cycle per word.
- wr_addr  out  ADDR_W  imem write address.
- wr_data  out  INSTR_W  imem write data.
- cpu_hold  out  1  high keeps the CPU in reset.
- done  out  1  image loaded; level signal.
- err  out  1  load failed; level signal.

Behaviour:
- Reset values: state IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0. All counters are 0.
- Byte transfer occurs when s_valid && s_ready on a rising edge. All outputs are registered.
- Stream format: N_lo, N_hi (16-bit little-endian word count N), then N words of BPW bytes each, little-endian. Bits above INSTR_W in the top byte are discarded.
- States:
  - IDLE: s_ready=0. start -> LEN_LO.
  - LEN_LO: s_ready=1. Byte -> N[7:0]; go to LEN_HI.
  - LEN_HI: s_ready=1. Byte -> N[15:8], then:
    - N==0 -> DONE.
    - N > 2^ADDR_W -> ERR.
    - otherwise -> DATA, with word counter=0 and byte index=0.
  - DATA: s_ready=1. Each byte shifts into the assembly register.
    - On the BPW-th byte of a word: on the same edge, wr_data=assembled word, wr_addr=word counter, wr_en=1 for exactly the next cycle. Word counter increments.
    - When word counter reaches N -> DONE (or CHK with the optional feature).
  - DONE: s_ready=0, done=1, cpu_hold=0.
  - ERR: s_ready=0, err=1, cpu_hold=1.
- Latency: wr_en is high in the cycle after the word's last byte handshake. done rises in the same cycle as the final wr_en.
- Back-to-back bytes at full rate are legal; no bubbles are required. s_valid gaps stall only.
- start in LEN_LO, LEN_HI, DATA or CHK is ignored.
- start in DONE or ERR -> LEN_LO. On that edge: done=0, err=0, cpu_hold=1, wr_addr counter cleared.
- N == 2^ADDR_W is legal; the last write goes to address 2^ADDR_W-1. The counter must not wrap before the compare, so it is ADDR_W+1 bits wide.
- rst asserted mid-load returns everything to reset values immediately (asynchronous). A partial image is left in imem, and cpu_hold is 1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, go to CHK (s_ready=1) and accept one byte.
  - The expected value is the XOR of all bytes from N_lo through the last data byte.
  - Match -> DONE. Mismatch -> ERR.
  - imem writes have already occurred; on ERR the CPU stays held.
  - With N==0, LEN_HI -> CHK.
- Not defined: no CHK state and no checksum register; the stream ends after the last data byte.

Decomposition:
- Shared package holds the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR) and a BYTE_W=8 constant.
- One natural sub-module: imem_loader_asm, the byte-to-word assembler. It contains the shift register and byte index, and outputs word_valid plus the word.

Test Plan:
- INSTR_W=16: start, then stream 02 00 34 12 CD AB. Required: wr_en pulses with (0,0x1234) then (1,0xABCD); done=1 and cpu_hold=0 in the cycle of the second wr_en.
- Stream 00 00. Required: DONE one cycle after the second byte, no wr_en, cpu_hold=0.
- ADDR_W=8, N=0x0101 (01 01). Required: err=1, s_ready=0, no writes, cpu_hold=1. Then start plus a valid stream recovers to done=1.
- Random s_valid gaps (50%) with N=4. Required: exactly 4 writes at addresses 0..3 with correct data; byte order is preserved.
- rst pulsed after 3 data bytes. Required: all outputs at reset values asynchronously, no further wr_en, and a fresh load succeeds.
- With IMEM_LOADER_CHECKSUM_EN, stream 01 00 34 12 + chk:
  - chk=0x27 (01^00^34^12) -> done=1.
  - chk=0x00 -> err=1, cpu_hold=1.
